muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 64: operand/result width (RV64 M extension).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 funct3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 is32  input  1  word variant (OP_32 opcode: MULW/DIVW/DIVUW/REMW/REMUW).
REQ-007 srcA, srcB  input  XLEN each  rs1/rs2 operands; sampled with start.
REQ-008 flush  input  1  pipeline flush; aborts any in-flight operation.
REQ-009 busy  output  1  high in every state except IDLE; the pipeline stalls on it.
REQ-010 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-011 result  output  XLEN  registered result; holds its value until the next accepted start.

Function
REQ-012 FSM states SHALL be IDLE, PREP, CALC, FIX and DONE, with transitions IDLE->PREP (start & !flush), PREP->CALC, CALC->FIX (after N iterations), FIX->DONE and DONE->IDLE.
REQ-013 N SHALL be XLEN for 64-bit ops and 32 for is32 ops, and an iteration counter SHALL count N..1 in CALC.
REQ-014 Latency: start accepted in cycle c gives done=1 in cycle c+N+3 (N=64: c+67; N=32: c+35).
REQ-015 PREP SHALL latch operands; signed ops (MUL*, MULH, MULHSU rs1 only, DIV, REM) take absolute values and record the result sign.
REQ-016 is32 ops SHALL use the low 32 operand bits, sign- or zero-extended per op, and the final result SHALL be its low 32 bits sign-extended to XLEN.
REQ-017 Multiply SHALL be shift-add, one bit per CALC cycle, into a 2*XLEN accumulator; MUL returns the low half and MULH/MULHSU/MULHU return the high half.
REQ-018 is32 with funct3 001..011 SHALL compute exactly as MULW.
REQ-019 Divide SHALL be restoring, one quotient bit per CALC cycle; FIX applies the quotient sign (rs1 xor rs2) and the remainder sign (rs1).
REQ-020 Divide by zero SHALL return quotient all-ones and remainder equal to the dividend (32-bit dividend, sign-extended, for word ops).
REQ-021 Signed overflow (most-negative / -1) SHALL return quotient equal to the dividend and remainder 0.
REQ-022 start asserted while busy SHALL be ignored, with no queuing.
REQ-023 flush SHALL force IDLE on the next edge from any state, with no done pulse and result unchanged; flush and start together in IDLE accept nothing.
REQ-024 done SHALL be high only in DONE; busy SHALL be low in IDLE, so back-to-back start is accepted the cycle after DONE.

Reset
REQ-025 reset SHALL take priority over flush and start: state IDLE, busy=0, done=0, result=0, counter=0, internal accumulators cleared.
REQ-026 reset asserted mid-operation SHALL abort it, and no done pulse follows.

Configuration
REQ-027 With MULDIV_EARLY_OUT_EN defined, the following SHALL skip CALC (PREP->FIX), giving done at c+3: divide by zero, signed overflow, and a multiply with either operand 0.
REQ-028 Without MULDIV_EARLY_OUT_EN, every operation SHALL take the full REQ-014 latency; results are identical in both builds.

Verification
REQ-029 MUL srcA=7, srcB=-3, is32=0 -> done at c+67, result=0xFFFFFFFFFFFFFFEB.
REQ-030 MULHU srcA=srcB=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE.
REQ-031 DIV srcA=0x8000000000000000, srcB=-1 -> result=0x8000000000000000; REM with the same operands -> result=0.
REQ-032 DIVUW srcA=100, srcB=0 -> result=0xFFFFFFFFFFFFFFFF; REMW srcA=0x00000000FFFFFFF9, srcB=2 -> result=0xFFFFFFFFFFFFFFFF (-7 rem 2 = -1); without the macro both complete at c+35, with it DIVUW-by-zero completes at c+3.
REQ-033 DIV 100/7 started, flush asserted at c+10 -> IDLE at c+11, no done, result unchanged; start at c+12 is accepted.
REQ-034 start pulsed at c+5 during a busy MUL -> ignored, exactly one done; reset asserted at c+20 of an op -> busy=0, result=0 next cycle, no done.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV64 M-extension multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to skip the iteration phase for trivial operands.
module muldiv_sequencer #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic            is32,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN + 1);

   typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

   state_e            state_q;
   logic [2:0]        fn_q;
   logic              w_q;
   logic [XLEN-1:0]   a_q, b_q, opb_q;
   logic [2*XLEN-1:0] acc_q;
   logic [CW-1:0]     cnt_q;
   logic              neg_q, rneg_q, div0_q, ovf_q, zero_q;

   logic [2:0]        efn;
   logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs, min_val;
   logic              p_div0, p_ovf, p_zero, skip;
   logic [2*XLEN-1:0] acc_init, acc_step, prod;
   logic [XLEN:0]     mul_sum, div_sh, div_diff;
   logic [XLEN-1:0]   quo, rem, mres, fres, res_fix;

   // Operand preparation; word multiplies of any flavour behave as MULW.
   always_comb begin
      efn   = (w_q && !fn_q[2]) ? 3'b000 : fn_q;
      is_div = efn[2];
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (efn)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         3'b010:  a_sgn = 1'b1;
         default: ;
      endcase
      a_ext = w_q ? {{(XLEN-32){a_sgn & a_q[31]}}, a_q[31:0]} : a_q;
      b_ext = w_q ? {{(XLEN-32){b_sgn & b_q[31]}}, b_q[31:0]} : b_q;
      a_neg = a_sgn & a_ext[XLEN-1];
      b_neg = b_sgn & b_ext[XLEN-1];
      a_abs = a_neg ? -a_ext : a_ext;
      b_abs = b_neg ? -b_ext : b_ext;
      min_val = w_q ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      p_div0 = is_div && (b_ext == '0);
      p_ovf  = is_div && a_sgn && (a_ext == min_val) && (b_ext == '1);
      p_zero = !is_div && ((a_ext == '0) || (b_ext == '0));
      // Word divides start with the dividend in the top half so 32 steps suffice.
      acc_init = {{XLEN{1'b0}}, (is_div && w_q) ? (a_abs << 32) : a_abs};
`ifdef MULDIV_EARLY_OUT_EN
      skip = p_div0 | p_ovf | p_zero;
`else
      skip = 1'b0;
`endif
   end

   // One iteration: multiply keeps {hi, multiplier}, divide keeps {remainder, quotient}.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff = div_sh - {1'b0, opb_q};
      if (!is_div) begin
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      end else if (!div_diff[XLEN]) begin
         acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_step = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
   end

   // Sign fix-up and special cases.
   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      if (zero_q) begin
         mres = '0;
      end else if (efn == 3'b000) begin
         mres = w_q ? {{(XLEN-32){1'b0}}, prod[XLEN-1 -: 32]} : prod[XLEN-1:0];
      end else begin
         mres = prod[2*XLEN-1:XLEN];
      end
      quo = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (div0_q) begin
         quo = '1;
         rem = a_q;
      end else if (ovf_q) begin
         quo = a_q;
         rem = '0;
      end
      fres    = is_div ? (efn[1] ? rem : quo) : mres;
      res_fix = w_q ? {{(XLEN-32){fres[31]}}, fres[31:0]} : fres;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         fn_q    <= '0;
         w_q     <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div0_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else if (flush) begin
         state_q <= StIdle;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  a_q     <= srcA;
                  b_q     <= srcB;
                  fn_q    <= funct3;
                  w_q     <= is32;
                  busy    <= 1'b1;
                  state_q <= StPrep;
               end
            end
            StPrep: begin
               acc_q   <= acc_init;
               opb_q   <= b_abs;
               neg_q   <= a_neg ^ b_neg;
               rneg_q  <= a_neg;
               div0_q  <= p_div0;
               ovf_q   <= p_ovf;
               zero_q  <= p_zero;
               cnt_q   <= w_q ? CW'(32) : CW'(XLEN);
               state_q <= skip ? StFix : StCalc;
            end
            StCalc: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= StFix;
            end
            StFix: begin
               result  <= res_fix;
               done    <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
